bj_resolve_unit: RTL and testbench

Parametrised branch/jump resolve unit for the LoongArch-32 ID→EX path. It decodes the nine branch/jump opcodes and compares the register operands. It then computes the target and link value, checks the front-end prediction, and queues each result in a 2-entry output buffer behind a valid/ready handshake. After a mispredict it blocks further input until the pipeline flush arrives.

---
 rtl/bj_pkg.sv | 36 +++
 rtl/bj_resolve_core.sv | 72 +++++++
 rtl/bj_resolve_unit.sv | 121 ++++++++++++
 tb/tb_bj_resolve_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - shared opcode constants, op codes and result record for the branch/jump resolve unit
package bj_pkg;

  localparam logic [5:0] OPC_JIRL = 6'b010011;
  localparam logic [5:0] OPC_B    = 6'b010100;
  localparam logic [5:0] OPC_BL   = 6'b010101;
  localparam logic [5:0] OPC_BEQ  = 6'b010110;
  localparam logic [5:0] OPC_BNE  = 6'b010111;
  localparam logic [5:0] OPC_BLT  = 6'b011000;
  localparam logic [5:0] OPC_BGE  = 6'b011001;
  localparam logic [5:0] OPC_BLTU = 6'b011010;
  localparam logic [5:0] OPC_BGEU = 6'b011011;

  localparam logic [7:0] OP_INVALID = 8'd0;
  localparam logic [7:0] OP_JIRL    = 8'd1;
  localparam logic [7:0] OP_B       = 8'd2;
  localparam logic [7:0] OP_BL      = 8'd3;
  localparam logic [7:0] OP_BEQ     = 8'd4;
  localparam logic [7:0] OP_BNE     = 8'd5;
  localparam logic [7:0] OP_BLT     = 8'd6;
  localparam logic [7:0] OP_BGE     = 8'd7;
  localparam logic [7:0] OP_BLTU    = 8'd8;
  localparam logic [7:0] OP_BGEU    = 8'd9;

  // Width-independent part of a resolved record; target and link data
  // travel beside it because their widths follow the unit's parameters.
  typedef struct packed {
    logic       is_bj;
    logic [7:0] op;
    logic       taken;
    logic       link_we;
    logic [4:0] link_rd;
    logic       mispredict;
  } bj_rec_t;

endpackage

// File: rtl/bj_resolve_core.sv
// rtl/bj_resolve_core.sv - combinational decode, compare, target and mispredict for one instruction
module bj_resolve_core
  import bj_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] pc,
  input  logic [XLEN-1:0] rj_val,
  input  logic [XLEN-1:0] rd_val,
  input  logic            pred_taken,
  input  logic [PC_W-1:0] pred_target,
  output bj_rec_t         rec,
  output logic [PC_W-1:0] target,
  output logic [XLEN-1:0] link_data
);

  logic [PC_W-1:0] offs16;
  logic [PC_W-1:0] offs26;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] tgt_taken;
  logic            eq;
  logic            lt_s;
  logic            lt_u;

  assign offs16 = {{(PC_W-18){inst[25]}}, inst[25:10], 2'b00};
  assign offs26 = {{(PC_W-28){inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign pc_seq = pc + PC_W'(4);
  assign eq     = (rj_val == rd_val);
  assign lt_s   = ($signed(rj_val) < $signed(rd_val));
  assign lt_u   = (rj_val < rd_val);

  always_comb begin
    rec       = '0;
    rec.op    = OP_INVALID;
    tgt_taken = pc + offs16;
    case (inst[31:26])
      OPC_JIRL: begin
        rec.op      = OP_JIRL;
        rec.taken   = 1'b1;
        rec.link_we = 1'b1;
        rec.link_rd = inst[4:0];
        tgt_taken   = rj_val[PC_W-1:0] + offs16;
      end
      OPC_B: begin
        rec.op    = OP_B;
        rec.taken = 1'b1;
        tgt_taken = pc + offs26;
      end
      OPC_BL: begin
        rec.op      = OP_BL;
        rec.taken   = 1'b1;
        rec.link_we = 1'b1;
        rec.link_rd = 5'd1;
        tgt_taken   = pc + offs26;
      end
      OPC_BEQ:  begin rec.op = OP_BEQ;  rec.taken = eq;    end
      OPC_BNE:  begin rec.op = OP_BNE;  rec.taken = !eq;   end
      OPC_BLT:  begin rec.op = OP_BLT;  rec.taken = lt_s;  end
      OPC_BGE:  begin rec.op = OP_BGE;  rec.taken = !lt_s; end
      OPC_BLTU: begin rec.op = OP_BLTU; rec.taken = lt_u;  end
      OPC_BGEU: begin rec.op = OP_BGEU; rec.taken = !lt_u; end
      default:  rec.op = OP_INVALID;
    endcase
    rec.is_bj      = (rec.op != OP_INVALID);
    target         = rec.taken ? tgt_taken : pc_seq;
    link_data      = XLEN'(pc_seq);
    rec.mispredict = (pred_taken != rec.taken) || (rec.taken && (pred_target != target));
  end

endmodule

// File: rtl/bj_resolve_unit.sv
// rtl/bj_resolve_unit.sv - branch/jump resolve unit with 2-entry output buffer and mispredict hold
// Optional perf counters when BJ_PERF_CNT_EN is defined.
module bj_resolve_unit
  import bj_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic [XLEN-1:0] in_rj_val,
  input  logic [XLEN-1:0] in_rd_val,
  input  logic            in_pred_taken,
  input  logic [PC_W-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_is_bj,
  output logic [7:0]      out_op,
  output logic            out_taken,
  output logic [PC_W-1:0] out_target,
  output logic            out_link_we,
  output logic [4:0]      out_link_rd,
  output logic [XLEN-1:0] out_link_data,
  output logic            out_mispredict
`ifdef BJ_PERF_CNT_EN
  ,
  output logic [31:0]     perf_bj_cnt,
  output logic [31:0]     perf_mispred_cnt
`endif
);

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t          state;
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  bj_rec_t         rec_q  [2];
  logic [PC_W-1:0] tgt_q  [2];
  logic [XLEN-1:0] link_q [2];

  bj_rec_t         rec_d;
  logic [PC_W-1:0] tgt_d;
  logic [XLEN-1:0] link_d;
  logic            push;
  logic            pop;

  bj_resolve_core #(.XLEN(XLEN), .PC_W(PC_W)) u_core (
    .inst        (in_inst),
    .pc          (in_pc),
    .rj_val      (in_rj_val),
    .rd_val      (in_rd_val),
    .pred_taken  (in_pred_taken),
    .pred_target (in_pred_target),
    .rec         (rec_d),
    .target      (tgt_d),
    .link_data   (link_d)
  );

  assign in_ready  = (state == ST_RUN) && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flush wins over everything; a popped head is still considered consumed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_RUN;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        rec_q[i]  <= '0;
        tgt_q[i]  <= '0;
        link_q[i] <= '0;
      end
    end else if (flush_i) begin
      state  <= ST_RUN;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        rec_q[wr_ptr]  <= rec_d;
        tgt_q[wr_ptr]  <= tgt_d;
        link_q[wr_ptr] <= link_d;
        wr_ptr         <= ~wr_ptr;
        if (rec_d.mispredict) state <= ST_HOLD;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_is_bj      = rec_q[rd_ptr].is_bj;
  assign out_op         = rec_q[rd_ptr].op;
  assign out_taken      = rec_q[rd_ptr].taken;
  assign out_target     = tgt_q[rd_ptr];
  assign out_link_we    = rec_q[rd_ptr].link_we;
  assign out_link_rd    = rec_q[rd_ptr].link_rd;
  assign out_link_data  = link_q[rd_ptr];
  assign out_mispredict = rec_q[rd_ptr].mispredict;

`ifdef BJ_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_bj_cnt      <= 32'd0;
      perf_mispred_cnt <= 32'd0;
    end else begin
      if (push && rec_d.is_bj)      perf_bj_cnt      <= perf_bj_cnt + 32'd1;
      if (push && rec_d.mispredict) perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bj_resolve_unit.sv
// tb/tb_bj_resolve_unit.sv - randomized self-checking bench for bj_resolve_unit against a queue-based model
module tb_bj_resolve_unit;
  import bj_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rj_val = '0;
  logic [31:0] in_rd_val = '0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] in_pred_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_is_bj;
  logic [7:0]  out_op;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_link_we;
  logic [4:0]  out_link_rd;
  logic [31:0] out_link_data;
  logic        out_mispredict;
`ifdef BJ_PERF_CNT_EN
  logic [31:0] perf_bj_cnt;
  logic [31:0] perf_mispred_cnt;
`endif

  bj_resolve_unit #(.XLEN(32), .PC_W(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush_i        (flush_i),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .in_pc          (in_pc),
    .in_rj_val      (in_rj_val),
    .in_rd_val      (in_rd_val),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_is_bj      (out_is_bj),
    .out_op         (out_op),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_link_we    (out_link_we),
    .out_link_rd    (out_link_rd),
    .out_link_data  (out_link_data),
    .out_mispredict (out_mispredict)
`ifdef BJ_PERF_CNT_EN
    ,
    .perf_bj_cnt      (perf_bj_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        is_bj;
    bit [7:0]  op;
    bit        taken;
    bit [31:0] target;
    bit        link_we;
    bit [4:0]  link_rd;
    bit [31:0] link_data;
    bit        mis;
  } mrec_t;

  mrec_t mq[$];
  bit    hold;
  int    n_checks;
  int    n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic mrec_t ref_model(logic [31:0] inst, logic [31:0] pc, logic [31:0] rj,
                                      logic [31:0] rd, logic pt, logic [31:0] ptgt);
    mrec_t       r;
    logic [15:0] f16;
    logic [25:0] f26;
    longint      o16;
    longint      o26;
    logic [31:0] seq;
    bit          cond;
    f16 = inst[25:10];
    f26 = {inst[9:0], inst[25:10]};
    o16 = longint'($signed(f16)) * 4;
    o26 = longint'($signed(f26)) * 4;
    seq = pc + 32'd4;
    r.is_bj = 0; r.op = OP_INVALID; r.taken = 0; r.target = seq;
    r.link_we = 0; r.link_rd = 0; r.link_data = seq;
    cond = 0;
    case (inst[31:26])
      6'h13: begin r.op = OP_JIRL; r.taken = 1; r.target = 32'(longint'(rj) + o16);
                   r.link_we = 1; r.link_rd = inst[4:0]; end
      6'h14: begin r.op = OP_B;  r.taken = 1; r.target = 32'(longint'(pc) + o26); end
      6'h15: begin r.op = OP_BL; r.taken = 1; r.target = 32'(longint'(pc) + o26);
                   r.link_we = 1; r.link_rd = 5'd1; end
      6'h16: begin r.op = OP_BEQ;  cond = 1; r.taken = (rj == rd); end
      6'h17: begin r.op = OP_BNE;  cond = 1; r.taken = (rj != rd); end
      6'h18: begin r.op = OP_BLT;  cond = 1; r.taken = ($signed(rj) <  $signed(rd)); end
      6'h19: begin r.op = OP_BGE;  cond = 1; r.taken = ($signed(rj) >= $signed(rd)); end
      6'h1A: begin r.op = OP_BLTU; cond = 1; r.taken = (rj <  rd); end
      6'h1B: begin r.op = OP_BGEU; cond = 1; r.taken = (rj >= rd); end
      default: ;
    endcase
    r.is_bj = (r.op != OP_INVALID);
    if (cond && r.taken) r.target = 32'(longint'(pc) + o16);
    r.mis = (pt != r.taken) || (r.taken && (ptgt != r.target));
    return r;
  endfunction

  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] rj, input logic [31:0] rd, input bit pt,
                      input logic [31:0] ptgt, input bit ordy, input bit fl);
    mrec_t r;
    bit    exp_ready, push, pop;
    in_valid = v; in_inst = inst; in_pc = pc; in_rj_val = rj; in_rd_val = rd;
    in_pred_taken = pt; in_pred_target = ptgt; out_ready = ordy; flush_i = fl;
    @(negedge clk);
    exp_ready = !hold && (mq.size() < 2);
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("is_bj", out_is_bj, mq[0].is_bj);
      check_eq("op", out_op, mq[0].op);
      check_eq("taken", out_taken, mq[0].taken);
      check_eq("target", out_target, mq[0].target);
      check_eq("link_we", out_link_we, mq[0].link_we);
      check_eq("link_rd", out_link_rd, mq[0].link_rd);
      check_eq("link_data", out_link_data, mq[0].link_data);
      check_eq("mispredict", out_mispredict, mq[0].mis);
    end
    r    = ref_model(inst, pc, rj, rd, pt, ptgt);
    push = v && exp_ready;
    pop  = ordy && (mq.size() != 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      hold = 0;
    end else begin
      if (pop) mq.delete(0);
      if (push) begin
        mq.push_back(r);
        if (r.mis) hold = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, ordy, 0);
  endtask

  task automatic async_reset();
    in_valid = 0; flush_i = 0;
    resetn = 0;
    #2;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 resetn = 1;
    mq.delete();
    hold = 0;
  endtask

  initial begin
    logic [31:0] inst, rj, rd, rnd, pc, ptgt;
    logic [5:0]  maj;
    bit          pt;
    mrec_t       r;
    logic [5:0]  opcs [9];
    opcs = '{6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B};
    n_checks = 0; n_fail = 0; hold = 0;

    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    check_eq("reset_out_valid", out_valid, 1'b0);
    check_eq("reset_in_ready", in_ready, 1'b1);
    check_eq("reset_target", out_target, 32'h0);
    check_eq("reset_link_data", out_link_data, 32'h0);
    check_eq("reset_op", out_op, 32'h0);
    @(posedge clk);
    #1;

    // BEQ taken, predicted not-taken: enters hold until flush
    step(1, {6'h16, 16'h0004, 10'h0}, 32'h1000, 32'd5, 32'd5, 0, 32'h0, 0, 0);
    check_eq("beq_target", out_target, 32'h1010);
    check_eq("beq_mis", out_mispredict, 1'b1);
    check_eq("beq_hold_ready", in_ready, 1'b0);
    idle(1);
    step(1, {6'h16, 16'h0004, 10'h0}, 32'h1000, 32'd5, 32'd5, 1, 32'h1010, 1, 0);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1, 1);
    check_eq("flush_ready", in_ready, 1'b1);
    idle(1);

    // BLT signed vs BLTU unsigned
    step(1, {6'h18, 16'h0008, 10'h0}, 32'h1100, 32'hFFFF_FFFF, 32'd1, 1, 32'h1120, 1, 0);
    check_eq("blt_taken", out_taken, 1'b1);
    step(1, {6'h1A, 16'h0008, 10'h0}, 32'h1200, 32'hFFFF_FFFF, 32'd1, 0, 32'h0, 1, 0);
    check_eq("bltu_target", out_target, 32'h1204);
    idle(1);

    // BL with offset -4
    step(1, {6'h15, 26'h3FF_FFFF}, 32'h2000, 32'h0, 32'h0, 1, 32'h1FFC, 1, 0);
    check_eq("bl_target", out_target, 32'h1FFC);
    check_eq("bl_link", out_link_data, 32'h2004);
    idle(1);

    // JIRL correct prediction stays in run
    step(1, {6'h13, 16'h0010, 5'd0, 5'd7}, 32'h4000, 32'h3000, 32'h0, 1, 32'h3040, 1, 0);
    check_eq("jirl_target", out_target, 32'h3040);
    check_eq("jirl_ready", in_ready, 1'b1);
    idle(1);

    // Fill with consumer stalled, then drain
    for (int i = 0; i < 3; i++)
      step(1, {6'h16, 16'h0001, 10'h0}, 32'h5000 + 32'(i * 4), 32'd1, 32'd2, 0, 32'h0, 0, 0);
    check_eq("full_ready", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) idle(1);

    // Invalid opcode predicted taken, then flush with a same-cycle push
    step(1, 32'h0, 32'h6000, 32'h0, 32'h0, 1, 32'h6100, 0, 0);
    check_eq("inv_op", out_op, OP_INVALID);
    check_eq("inv_mis", out_mispredict, 1'b1);
    step(1, {6'h14, 26'h10}, 32'h6000, 32'h0, 32'h0, 0, 32'h0, 0, 1);
    check_eq("flush_drop_valid", out_valid, 1'b0);
    step(1, {6'h14, 26'h10}, 32'h7000, 32'h0, 32'h0, 0, 32'h0, 0, 0);
    step(1, {6'h17, 16'h2, 10'h0}, 32'h7100, 32'h1, 32'h1, 0, 32'h0, 0, 1);
    check_eq("flush_run_drop", out_valid, 1'b0);
    idle(1);

    for (int n = 0; n < 3000; n++) begin
      rnd  = $urandom();
      maj  = ($urandom_range(0, 9) == 9) ? rnd[31:26] : opcs[$urandom_range(0, 8)];
      inst = {maj, rnd[25:0]};
      rd   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rj = rd;
        1: rj = 32'($urandom_range(0, 3));
        2: rj = ~rd;
        default: rj = $urandom();
      endcase
      pc = $urandom();
      r  = ref_model(inst, pc, rj, rd, 0, 32'h0);
      if ($urandom_range(0, 3) != 0) begin
        pt = r.taken; ptgt = r.target;
      end else begin
        pt = 1'($urandom_range(0, 1)); ptgt = ($urandom_range(0, 1) == 1) ? r.target : $urandom();
      end
      step(1'($urandom_range(0, 3) != 0), inst, pc, rj, rd, pt, ptgt,
           1'($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
      if (n % 700 == 350) async_reset();
    end
    for (int i = 0; i < 3; i++) idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
